accel_poll_sched: RTL and testbench

Scheduler/arbiter in front of the accelerometer SPI register-read controller. Periodically sweeps the X, Y, Z data registers, one register-read transaction per axis, and interleaves one-shot host register reads at transaction boundaries. Presents a coherent X/Y/Z sample with a valid pulse. Sits between the reader FSM (start/ready handshake) and the application logic.

---
 rtl/accel_pkg.sv | 25 ++
 rtl/accel_tick_gen.sv | 37 +++
 rtl/accel_poll_sched.sv | 211 +++++++++++++++++++++
 tb/tb_accel_poll_sched.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the accelerometer poll scheduler.
//   state_t  - scheduler FSM states
//   axis_t   - sweep axis index (X=0, Y=1, Z=2)
//   DEF_ADDR_* - default data register addresses of the accelerometer
package accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_CAPTURE
    } state_t;

    typedef enum logic [1:0] {
        AXIS_X = 2'd0,
        AXIS_Y = 2'd1,
        AXIS_Z = 2'd2
    } axis_t;

    localparam logic [7:0] DEF_ADDR_X = 8'h08;
    localparam logic [7:0] DEF_ADDR_Y = 8'h09;
    localparam logic [7:0] DEF_ADDR_Z = 8'h0A;

endpackage

// File: rtl/accel_tick_gen.sv
// accel_tick_gen: free-running period counter for the sweep scheduler.
// Counts 0..PERIOD-1 while enable is high and emits a one-cycle tick on the
// cycle after the wrap. Dropping enable clears the count.
// Ports:
//   ck     - clock (rising edge)
//   rst    - synchronous active-high reset
//   enable - counting enable; low clears the counter
//   tick   - one-cycle pulse once per PERIOD cycles
module accel_tick_gen
    import accel_pkg::*;
#(
    parameter int PERIOD = 100000
) (
    input  logic ck,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge ck) begin
        if (rst || !enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/accel_poll_sched.sv
// accel_poll_sched: scheduler/arbiter in front of the SPI register-read
// controller. Sweeps the X, Y, Z data registers once per PERIOD and slots
// one-shot host reads in between transactions (host has priority). A sample
// is published only when all three axes of one sweep have been read.
// Optional watchdog: define ACCEL_POLL_TIMEOUT_EN to abort reads that stall
// for TIMEOUT cycles (timeout_err is tied low otherwise).
// Ports:
//   ck, rst                 - clock, synchronous active-high reset
//   enable                  - enables periodic sweeps
//   host_req/host_addr      - host read request (held until host_ack)
//   host_ack/host_data      - host read completion pulse and data
//   rd_start/rd_addr        - start pulse and address to the reader
//   rd_ready/rd_data        - reader idle flag and result
//   x_out/y_out/z_out       - last complete sample
//   sample_valid            - one-cycle pulse when a sample is published
//   overrun                 - sticky: tick arrived with a sweep outstanding
//   busy                    - FSM not in IDLE
//   timeout_err             - sticky: watchdog expired
module accel_poll_sched
    import accel_pkg::*;
#(
    parameter int         PERIOD  = 100000,
    parameter logic [7:0] ADDR_X  = DEF_ADDR_X,
    parameter logic [7:0] ADDR_Y  = DEF_ADDR_Y,
    parameter logic [7:0] ADDR_Z  = DEF_ADDR_Z,
    parameter int         TIMEOUT = 1024
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       enable,
    input  logic       host_req,
    input  logic [7:0] host_addr,
    output logic       host_ack,
    output logic [7:0] host_data,
    output logic       rd_start,
    output logic [7:0] rd_addr,
    input  logic       rd_ready,
    input  logic [7:0] rd_data,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [7:0] z_out,
    output logic       sample_valid,
    output logic       overrun,
    output logic       busy,
    output logic       timeout_err
);

    if (PERIOD < 2) begin : g_period_chk
        $error("accel_poll_sched: PERIOD must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("accel_poll_sched: TIMEOUT must be >= 1");
    end

    state_t     state;
    axis_t      axis;        // next (or in-flight) sweep axis
    logic       cur_host;    // in-flight transaction belongs to the host
    logic       sweep_pend;  // a sweep is pending or partially done
    logic       drop;        // in-flight sweep result must be discarded
    logic       tick;
    logic       tick_en;
    logic       sweep_cap;
    logic [7:0] x_sh;
    logic [7:0] y_sh;

    function automatic logic [7:0] axis_addr(input axis_t a);
        case (a)
            AXIS_X:  return ADDR_X;
            AXIS_Y:  return ADDR_Y;
            default: return ADDR_Z;
        endcase
    endfunction

    accel_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .ck     (ck),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // The tick is registered, so gate it in the cycle enable falls.
    assign tick_en   = tick && enable;
    assign busy      = (state != S_IDLE);
    assign sweep_cap = (state == S_WAIT_HI) && rd_ready && !cur_host && !drop;

`ifdef ACCEL_POLL_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;
    logic           wd_expired;
    assign wd_expired = (wd == WDW'(TIMEOUT - 1));
`else
    assign timeout_err = 1'b0;
`endif

    // X and Y are parked here until Z arrives; Z goes straight to z_out.
    always_ff @(posedge ck) begin
        if (sweep_cap && axis == AXIS_X) x_sh <= rd_data;
        if (sweep_cap && axis == AXIS_Y) y_sh <= rd_data;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state        <= S_IDLE;
            axis         <= AXIS_X;
            cur_host     <= 1'b0;
            sweep_pend   <= 1'b0;
            drop         <= 1'b0;
            rd_start     <= 1'b0;
            rd_addr      <= '0;
            host_ack     <= 1'b0;
            host_data    <= '0;
            sample_valid <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            z_out        <= '0;
            overrun      <= 1'b0;
`ifdef ACCEL_POLL_TIMEOUT_EN
            timeout_err  <= 1'b0;
            wd           <= '0;
`endif
        end else begin
            rd_start     <= 1'b0;
            host_ack     <= 1'b0;
            sample_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rd_ready) begin
                        if (host_req) begin
                            cur_host <= 1'b1;
                            rd_addr  <= host_addr;
                            rd_start <= 1'b1;
                            state    <= S_ISSUE;
                        end else if (sweep_pend) begin
                            cur_host <= 1'b0;
                            rd_addr  <= axis_addr(axis);
                            drop     <= 1'b0;
                            rd_start <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!rd_ready) state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // Capture results here so host_ack/sample_valid are
                    // registered and visible during the CAPTURE cycle.
                    if (rd_ready) begin
                        state <= S_CAPTURE;
                        if (cur_host) begin
                            host_data <= rd_data;
                            host_ack  <= 1'b1;
                        end else if (!drop) begin
                            case (axis)
                                AXIS_X: axis <= AXIS_Y;
                                AXIS_Y: axis <= AXIS_Z;
                                default: begin
                                    x_out        <= x_sh;
                                    y_out        <= y_sh;
                                    z_out        <= rd_data;
                                    sample_valid <= 1'b1;
                                    sweep_pend   <= 1'b0;
                                    axis         <= AXIS_X;
                                end
                            endcase
                        end
                    end
                end
                S_CAPTURE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase

`ifdef ACCEL_POLL_TIMEOUT_EN
            if (state == S_ISSUE) begin
                wd <= '0;
            end else if (state == S_WAIT_LO || state == S_WAIT_HI) begin
                wd <= wd + 1'b1;
                // A completion in the expiry cycle still wins.
                if (wd_expired && !(state == S_WAIT_HI && rd_ready)) begin
                    state       <= S_IDLE;
                    timeout_err <= 1'b1;
                    if (!cur_host) begin
                        sweep_pend <= 1'b0;
                        axis       <= AXIS_X;
                    end
                end
            end
`endif

            if (tick_en) begin
                if (sweep_pend) begin
                    overrun <= 1'b1;
                end else begin
                    sweep_pend <= 1'b1;
                    axis       <= AXIS_X;
                end
            end

            // Disabling kills the sweep; any in-flight sweep read finishes
            // on the bus but its data is thrown away.
            if (!enable) begin
                sweep_pend <= 1'b0;
                axis       <= AXIS_X;
                drop       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accel_poll_sched.sv
module tb_accel_poll_sched;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       rst       = 1'b1;
    logic       en0       = 1'b0;
    logic       en1       = 1'b0;
    logic       host_req  = 1'b0;
    logic       stuck     = 1'b0;
    logic [7:0] host_addr = 8'h00;

    logic       host_ack     [2];
    logic [7:0] host_data    [2];
    logic       rd_start     [2];
    logic [7:0] rd_addr      [2];
    logic       rd_ready     [2] = '{1'b1, 1'b1};
    logic [7:0] rd_data      [2] = '{8'h00, 8'h00};
    logic [7:0] x_out        [2];
    logic [7:0] y_out        [2];
    logic [7:0] z_out        [2];
    logic       sample_valid [2];
    logic       overrun      [2];
    logic       busy         [2];
    logic       timeout_err  [2];

    int n_chk  = 0;
    int n_pass = 0;

    accel_poll_sched #(
        .PERIOD(200), .ADDR_X(8'h08), .ADDR_Y(8'h09), .ADDR_Z(8'h0A), .TIMEOUT(64)
    ) dut0 (
        .ck(ck), .rst(rst), .enable(en0), .host_req(host_req), .host_addr(host_addr),
        .host_ack(host_ack[0]), .host_data(host_data[0]),
        .rd_start(rd_start[0]), .rd_addr(rd_addr[0]),
        .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
        .x_out(x_out[0]), .y_out(y_out[0]), .z_out(z_out[0]),
        .sample_valid(sample_valid[0]), .overrun(overrun[0]), .busy(busy[0]),
        .timeout_err(timeout_err[0])
    );

    accel_poll_sched #(
        .PERIOD(40), .ADDR_X(8'h08), .ADDR_Y(8'h09), .ADDR_Z(8'h0A), .TIMEOUT(1024)
    ) dut1 (
        .ck(ck), .rst(rst), .enable(en1), .host_req(1'b0), .host_addr(8'h00),
        .host_ack(host_ack[1]), .host_data(host_data[1]),
        .rd_start(rd_start[1]), .rd_addr(rd_addr[1]),
        .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
        .x_out(x_out[1]), .y_out(y_out[1]), .z_out(z_out[1]),
        .sample_valid(sample_valid[1]), .overrun(overrun[1]), .busy(busy[1]),
        .timeout_err(timeout_err[1])
    );

    // Reader model: ready drops the cycle after start, returns addr+0x40
    // about 20 cycles later; 'stuck' holds it low indefinitely.
    for (genvar g = 0; g < 2; g++) begin : g_rdr
        logic [4:0] cnt = 5'd0;
        logic [7:0] a   = 8'h00;
        always @(posedge ck) begin
            if (rd_start[g] === 1'b1) begin
                rd_ready[g] <= 1'b0;
                cnt         <= 5'd19;
                a           <= rd_addr[g];
            end else if (cnt != 5'd0) begin
                if (!(cnt == 5'd1 && stuck)) cnt <= cnt - 5'd1;
                if (cnt == 5'd1 && !stuck) begin
                    rd_ready[g] <= 1'b1;
                    rd_data[g]  <= a + 8'h40;
                end
            end
        end
    end

    // Event logs
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];
    int sv0 = 0, sv1 = 0, acks = 0, viol0 = 0, viol1 = 0;

    always @(negedge ck) begin
        if (rd_start[0] === 1'b1) begin
            log0.push_back(rd_addr[0]);
            if (rd_ready[0] !== 1'b1) viol0++;
        end
        if (sample_valid[0] === 1'b1) sv0++;
        if (host_ack[0] === 1'b1) acks++;
    end

    always @(negedge ck) begin
        if (rd_start[1] === 1'b1) begin
            log1.push_back(rd_addr[1]);
            if (rd_ready[1] !== 1'b1) viol1++;
        end
        if (sample_valid[1] === 1'b1) sv1++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge ck);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; host_req = 1'b0;
        step(2);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({rd_start[i], host_ack[i], sample_valid[i], overrun[i], busy[i], timeout_err[i]} !== 6'b0)
                $display("FAIL reset_ctrl[%0d]: got %b want 000000", i,
                         {rd_start[i], host_ack[i], sample_valid[i], overrun[i], busy[i], timeout_err[i]});
            else n_pass++;
            n_chk++;
            if ({rd_addr[i], host_data[i], x_out[i], y_out[i], z_out[i]} !== 40'h0)
                $display("FAIL reset_data[%0d]: got %h want 0", i,
                         {rd_addr[i], host_data[i], x_out[i], y_out[i], z_out[i]});
            else n_pass++;
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_sweep();
        int b, s;
        bit ok;
        logic [23:0] seq;
        do_reset();
        b = log0.size(); s = sv0; en0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (sv0 > s) ok = 1'b1;
        end
        n_chk++;
        if (!ok) $display("FAIL sweep_done: no sample_valid within 400 cycles");
        else n_pass++;
        seq = '1;
        for (int i = 0; i < 3; i++) if (b + i < log0.size()) seq[23-8*i -: 8] = log0[b+i];
        n_chk++;
        if (seq !== 24'h08090A || log0.size() - b != 3)
            $display("FAIL sweep_order: got %h (%0d starts) want 08090a (3)", seq, log0.size() - b);
        else n_pass++;
        n_chk++;
        if ({x_out[0], y_out[0], z_out[0]} !== 24'h48494A)
            $display("FAIL sweep_xyz: got %h want 48494a", {x_out[0], y_out[0], z_out[0]});
        else n_pass++;
        n_chk++;
        if (busy[0] !== 1'b1) $display("FAIL sweep_busy_capture: got %b want 1", busy[0]);
        else n_pass++;
        step();
        n_chk++;
        if (sample_valid[0] !== 1'b0 || sv0 - s != 1)
            $display("FAIL sweep_sv_pulse: got sv=%b count=%0d want 0 / 1", sample_valid[0], sv0 - s);
        else n_pass++;
        en0 = 1'b0;
        step(30);
    endtask

    task automatic test_host_interleave();
        int b, s, a;
        bit ok;
        logic [7:0] x_at, hd;
        logic [31:0] seq;
        do_reset();
        b = log0.size(); s = sv0; a = acks; en0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (log0.size() > b) ok = 1'b1;
        end
        n_chk++;
        if (!ok) $display("FAIL host_x_start: no X start within 300 cycles");
        else n_pass++;
        host_addr = 8'h0B; host_req = 1'b1;
        ok = 1'b0; x_at = 8'hFF; hd = 8'hFF;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (host_ack[0] === 1'b1) begin
                host_req = 1'b0;
                x_at = x_out[0];
                hd = host_data[0];
            end
            if (sv0 > s) ok = 1'b1;
        end
        host_req = 1'b0;
        n_chk++;
        if (!ok) $display("FAIL host_sweep_done: no sample_valid within 400 cycles");
        else n_pass++;
        seq = '1;
        for (int i = 0; i < 4; i++) if (b + i < log0.size()) seq[31-8*i -: 8] = log0[b+i];
        n_chk++;
        if (seq !== 32'h080B090A || log0.size() - b != 4)
            $display("FAIL host_order: got %h (%0d starts) want 080b090a (4)", seq, log0.size() - b);
        else n_pass++;
        n_chk++;
        if (acks - a != 1 || hd !== 8'h4B)
            $display("FAIL host_ack_data: got %0d acks data %h want 1 acks data 4b", acks - a, hd);
        else n_pass++;
        n_chk++;
        if (x_at !== 8'h00) $display("FAIL host_x_not_early: got x_out=%h at host_ack want 00", x_at);
        else n_pass++;
        n_chk++;
        if ({x_out[0], y_out[0], z_out[0]} !== 24'h48494A)
            $display("FAIL host_xyz: got %h want 48494a", {x_out[0], y_out[0], z_out[0]});
        else n_pass++;
        en0 = 1'b0;
        step(30);
    endtask

    task automatic test_overrun();
        int b, s, bad;
        bit ok;
        do_reset();
        b = log1.size(); s = sv1; en1 = 1'b1;
        step(60);
        n_chk++;
        if (overrun[1] !== 1'b0 || busy[1] !== 1'b1)
            $display("FAIL ovr_early: got overrun=%b busy=%b want 0/1", overrun[1], busy[1]);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            step();
            if (sv1 - s >= 3) ok = 1'b1;
        end
        n_chk++;
        if (!ok) $display("FAIL ovr_three_sweeps: got %0d sample_valid in 1000 cycles want 3", sv1 - s);
        else n_pass++;
        n_chk++;
        if (overrun[1] !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun[1]);
        else n_pass++;
        bad = 0;
        for (int i = b; i < log1.size(); i++) if (log1[i] !== 8'h08 + 8'((i - b) % 3)) bad++;
        n_chk++;
        if (log1.size() - b != 9 || sv1 - s != 3 || bad != 0)
            $display("FAIL ovr_one_sv_per_sweep: got %0d starts %0d sv %0d misordered want 9/3/0",
                     log1.size() - b, sv1 - s, bad);
        else n_pass++;
        n_chk++;
        if ({x_out[1], y_out[1], z_out[1]} !== 24'h48494A)
            $display("FAIL ovr_xyz: got %h want 48494a", {x_out[1], y_out[1], z_out[1]});
        else n_pass++;
        en1 = 1'b0;
        step(30);
    endtask

    task automatic test_enable_drop();
        int b, s, a;
        bit ok;
        logic [23:0] seq;
        do_reset();
        b = log0.size(); s = sv0; en0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (log0.size() - b >= 2) ok = 1'b1;
        end
        n_chk++;
        if (!ok) $display("FAIL drop_y_start: no Y start within 400 cycles");
        else n_pass++;
        step(3);
        en0 = 1'b0;
        step(60);
        n_chk++;
        if (log0.size() - b != 2 || sv0 != s)
            $display("FAIL drop_no_z: got %0d starts %0d sv want 2/0", log0.size() - b, sv0 - s);
        else n_pass++;
        n_chk++;
        if (x_out[0] !== 8'h00 || busy[0] !== 1'b0)
            $display("FAIL drop_outputs: got x_out=%h busy=%b want 00/0", x_out[0], busy[0]);
        else n_pass++;
        a = acks; host_addr = 8'h0C; host_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (host_ack[0] === 1'b1) begin
                host_req = 1'b0;
                ok = 1'b1;
            end
        end
        host_req = 1'b0;
        n_chk++;
        if (!ok || host_data[0] !== 8'h4C)
            $display("FAIL drop_host_served: got ack=%b data=%h want 1/4c", ok, host_data[0]);
        else n_pass++;
        b = log0.size(); s = sv0; en0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (sv0 > s) ok = 1'b1;
        end
        seq = '1;
        for (int i = 0; i < 3; i++) if (b + i < log0.size()) seq[23-8*i -: 8] = log0[b+i];
        n_chk++;
        if (!ok || seq !== 24'h08090A || {x_out[0], y_out[0], z_out[0]} !== 24'h48494A)
            $display("FAIL drop_reenable: got done=%b order=%h xyz=%h want 1/08090a/48494a",
                     ok, seq, {x_out[0], y_out[0], z_out[0]});
        else n_pass++;
        en0 = 1'b0;
        step(30);
    endtask

    task automatic test_reset_mid();
        int b, a;
        bit ok;
        b = log0.size(); a = acks;
        host_addr = 8'h0B; host_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (log0.size() > b) ok = 1'b1;
        end
        n_chk++;
        if (!ok) $display("FAIL rmid_start: no start within 50 cycles");
        else n_pass++;
        step(8);
        rst = 1'b1;
        step(1);
        n_chk++;
        if ({rd_start[0], host_ack[0], sample_valid[0], overrun[0], busy[0], timeout_err[0]} !== 6'b0)
            $display("FAIL rmid_ctrl: got %b want 000000",
                     {rd_start[0], host_ack[0], sample_valid[0], overrun[0], busy[0], timeout_err[0]});
        else n_pass++;
        n_chk++;
        if ({rd_addr[0], host_data[0], x_out[0], y_out[0], z_out[0]} !== 40'h0)
            $display("FAIL rmid_data: got %h want 0",
                     {rd_addr[0], host_data[0], x_out[0], y_out[0], z_out[0]});
        else n_pass++;
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (host_ack[0] === 1'b1) begin
                host_req = 1'b0;
                ok = 1'b1;
            end
        end
        host_req = 1'b0;
        n_chk++;
        if (!ok || acks - a != 1 || host_data[0] !== 8'h4B || log0.size() - b != 2)
            $display("FAIL rmid_retry: got ack=%b acks=%0d data=%h starts=%0d want 1/1/4b/2",
                     ok, acks - a, host_data[0], log0.size() - b);
        else n_pass++;
        step(5);
    endtask

`ifdef ACCEL_POLL_TIMEOUT_EN
    task automatic test_timeout();
        int b, a;
        bit ok;
        do_reset();
        b = log0.size(); a = acks;
        stuck = 1'b1; host_addr = 8'h0D; host_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (log0.size() > b) ok = 1'b1;
        end
        step(64);
        n_chk++;
        if (!ok || timeout_err[0] !== 1'b0 || busy[0] !== 1'b1)
            $display("FAIL tmo_before: got start=%b err=%b busy=%b want 1/0/1", ok, timeout_err[0], busy[0]);
        else n_pass++;
        step(1);
        n_chk++;
        if (timeout_err[0] !== 1'b1 || busy[0] !== 1'b0 || acks != a)
            $display("FAIL tmo_expire: got err=%b busy=%b acks=%0d want 1/0/0", timeout_err[0], busy[0], acks - a);
        else n_pass++;
        stuck = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (host_ack[0] === 1'b1) begin
                host_req = 1'b0;
                ok = 1'b1;
            end
        end
        host_req = 1'b0;
        n_chk++;
        if (!ok || host_data[0] !== 8'h4D || timeout_err[0] !== 1'b1)
            $display("FAIL tmo_retry: got ack=%b data=%h err=%b want 1/4d/1", ok, host_data[0], timeout_err[0]);
        else n_pass++;
        step(5);
    endtask
`endif

    task automatic test_protocol();
        n_chk++;
        if (viol0 + viol1 != 0)
            $display("FAIL start_while_not_ready: got %0d occurrences want 0", viol0 + viol1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_host_interleave();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
`ifdef ACCEL_POLL_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
